mem_store: RTL and testbench
============================

MEM_STORE -- requirements
Module: mem_store

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port rdy, input, 1 bit: global ready; when low, the block freezes.
REQ-004 SHALL have port store_req, input, 1 bit: store request from the MEM stage.
REQ-005 SHALL have port store_addr, input, 32 bits: byte address of the store.
REQ-006 SHALL have port store_data, input, 32 bits: store data, little-endian, byte 0 = bits 7:0.
REQ-007 SHALL have port store_size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
REQ-008 SHALL have port store_ready, output, 1 bit: the block can accept a request this cycle.
REQ-009 SHALL have port store_done, output, 1 bit: one-cycle pulse when the last byte has been written.
REQ-010 SHALL have port bus_req, output, 1 bit: requests the RAM bus from the arbiter.
REQ-011 SHALL have port bus_gnt, input, 1 bit: bus granted to this block.
REQ-012 SHALL have port addr_ram, output, 32 bits: RAM/IO byte address.
REQ-013 SHALL have port dout_ram, output, 8 bits: write byte.
REQ-014 SHALL have port wr_ram, output, 1 bit: write strobe, 1 = write.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_GNT, WRITE, DONE.
REQ-016 SHALL drive store_ready = 1 only in IDLE.
REQ-017 SHALL accept a request when store_req & store_ready & rdy:
- latch addr, data and byte count N (1/2/4) from store_size
- clear byte index idx
- go to WAIT_GNT.
REQ-018 SHALL drive bus_req = 1 in the WAIT_GNT, WRITE and DONE states, and 0 in IDLE.
REQ-019 WAIT_GNT: SHALL go to WRITE when bus_gnt & rdy; otherwise stay.
REQ-020 WRITE: SHALL present one byte per cycle:
- addr_ram = latched addr + idx, modulo 2^32
- dout_ram = latched data byte idx
- wr_ram = 1.
REQ-021 WRITE: on each cycle with rdy & bus_gnt, SHALL increment idx; when idx == N-1, SHALL go to DONE instead of incrementing.
REQ-022 DONE: SHALL assert store_done for exactly one cycle with wr_ram = 0, then go to IDLE.
REQ-023 SHALL force wr_ram to 0 whenever rdy = 0 or bus_gnt = 0, and SHALL hold all state and addr_ram/dout_ram unchanged; no byte is written twice or skipped.
REQ-024 SHALL drive wr_ram = 0, addr_ram = 0 and dout_ram = 0 in IDLE and WAIT_GNT.
REQ-025 SHALL not check alignment: misaligned halfword/word stores write consecutive bytes, including across the 0x20000 boundary.
REQ-026 SHALL treat IO addresses (addr[17:16] == 2'b11, e.g. 0x30000, 0x30004) identically to RAM; byte order and count are unchanged.
REQ-027 Latency: with bus_gnt and rdy held high, a request accepted in cycle T produces:
- bytes in cycles T+2 .. T+1+N
- store_done in cycle T+2+N
- store_ready again in cycle T+3+N.
REQ-028 SHALL ignore store_req while not in IDLE; it SHALL not change the latched request.

Reset
REQ-029 While rst = 1 at a clock edge, SHALL enter IDLE and clear idx and the latched registers, independent of rdy.
REQ-030 After reset, SHALL output store_ready = 1, store_done = 0, bus_req = 0, wr_ram = 0, addr_ram = 0, dout_ram = 0.
REQ-031 A reset during WRITE SHALL abort the store immediately: no further bytes are written and no store_done is issued.

Verification
REQ-032 SW addr 0x00001000, data 0xA1B2C3D4, gnt = rdy = 1 -> wr_ram pulses at 0x1000..0x1003 with bytes D4, C3, B2, A1 in T+2..T+5; store_done at T+6.
REQ-033 SB addr 0x00030000, data 0x00000041 -> exactly one write: 0x41 to 0x30000; store_done at T+3.
REQ-034 SH addr 0x0001FFFF, data 0x00005566, rdy low for 2 cycles after the first byte -> 0x66 to 0x1FFFF; wr_ram = 0 during the pause; then 0x55 to 0x20000; no duplicate write.
REQ-035 SW with bus_gnt held 0 for 3 cycles in WAIT_GNT -> no wr_ram until gnt rises; then 4 consecutive byte writes; bus_req stays high throughout.
REQ-036 rst asserted in the cycle after the second byte of a SW -> only 2 bytes written; store_done never asserted; store_ready = 1 on the next cycle.
REQ-037 store_req held high during a SW, followed by an SB request -> SB accepted only after store_done; the SW bytes are not corrupted.

Source files
------------

// File: rtl/mem_store.sv
// mem_store: serialises a byte/halfword/word store from the MEM stage into single-byte RAM/IO writes.
// Latency: accepted in cycle T -> bytes T+2..T+1+N, store_done T+2+N, store_ready again T+3+N.
// Backpressure: rdy low or bus_gnt low freezes the FSM and suppresses wr_ram; store_req is ignored outside IDLE.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; low freezes all state
//   store_req/addr/data/size   request from MEM stage (size 00=B, 01=H, 1x=W)
//   store_ready       high only in IDLE
//   store_done        one-cycle pulse as the store completes
//   bus_req/bus_gnt   RAM bus arbitration
//   addr_ram/dout_ram/wr_ram   byte-wide write port

module mem_store (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        store_req,
   input  logic [31:0] store_addr,
   input  logic [31:0] store_data,
   input  logic [1:0]  store_size,
   output logic        store_ready,
   output logic        store_done,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [31:0] addr_ram,
   output logic [7:0]  dout_ram,
   output logic        wr_ram
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      WRITE    = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [1:0]  last_q;   // index of the final byte (N-1)
   logic [1:0]  idx_q;
   logic [1:0]  last_d;
   logic        accept;
   logic        step;
   logic [7:0]  byte_sel;

   // Byte count N is kept as N-1 so the end test is a plain compare with idx.
   always_comb begin
      last_d = 2'd3;
      case (store_size)
         2'b00:   last_d = 2'd0;
         2'b01:   last_d = 2'd1;
         default: last_d = 2'd3;
      endcase
   end

   assign accept = store_req & (state_q == IDLE) & rdy;
   assign step   = rdy & bus_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         last_q  <= 2'd0;
         idx_q   <= 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q  <= store_addr;
                  data_q  <= store_data;
                  last_q  <= last_d;
                  idx_q   <= 2'd0;
                  state_q <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (step) state_q <= WRITE;
            end
            WRITE: begin
               // A byte only counts as written in a cycle where the strobe was
               // actually allowed out, so stalls never skip or repeat a byte.
               if (step) begin
                  if (idx_q == last_q) state_q <= DONE;
                  else                 idx_q   <= idx_q + 2'd1;
               end
            end
            DONE: begin
               if (rdy) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      byte_sel = data_q[7:0];
      case (idx_q)
         2'd0: byte_sel = data_q[7:0];
         2'd1: byte_sel = data_q[15:8];
         2'd2: byte_sel = data_q[23:16];
         2'd3: byte_sel = data_q[31:24];
         default: byte_sel = data_q[7:0];
      endcase
   end

   assign store_ready = (state_q == IDLE);
   assign bus_req     = (state_q != IDLE);

   // Address and data are decoded from held registers, so they stay put while
   // frozen; only the strobe and done pulse see the live stall/reset inputs.
   assign addr_ram = (state_q == WRITE) ? (addr_q + {30'd0, idx_q}) : 32'd0;
   assign dout_ram = (state_q == WRITE) ? byte_sel : 8'd0;

   // Gating with rst keeps an in-flight store from emitting a byte in the
   // cycle that aborts it.
   assign wr_ram     = (state_q == WRITE) & step & ~rst;
   assign store_done = (state_q == DONE) & rdy & ~rst;

endmodule

// File: tb/tb_mem_store.sv
// tb_mem_store: scoreboard bench for mem_store; expected byte writes and done
// pulses are queued at stimulus time and retired by a negedge monitor.
// Timed entries also check the cycle in which each event appears.

module tb_mem_store;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        store_req;
   logic [31:0] store_addr;
   logic [31:0] store_data;
   logic [1:0]  store_size;
   logic        store_ready;
   logic        store_done;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] addr_ram;
   logic [7:0]  dout_ram;
   logic        wr_ram;

   mem_store dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .store_req  (store_req),
      .store_addr (store_addr),
      .store_data (store_data),
      .store_size (store_size),
      .store_ready(store_ready),
      .store_done (store_done),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .addr_ram   (addr_ram),
      .dout_ram   (dout_ram),
      .wr_ram     (wr_ram)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
      int          c;   // expected cycle, -1 = any
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: retire expected writes / done pulses as they appear.
   exp_t mon_e;
   int   mon_dc;
   always @(negedge clk) begin
      if (!rdy || !bus_gnt) chk("wr_gated", wr_ram, 0);
      if (wr_ram) begin
         chk("wr_busreq", bus_req, 1);
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", addr_ram, mon_e.a);
            chk("wr_data", dout_ram, mon_e.d);
            if (mon_e.c >= 0) chk("wr_cyc", cyc, mon_e.c);
         end
      end
      if (store_done) begin
         chk("done_wr_low", wr_ram, 0);
         if (done_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
         end else begin
            mon_dc = done_q.pop_front();
            if (mon_dc >= 0) chk("done_cyc", cyc, mon_dc);
         end
      end
   end

   // Drive a single-cycle request; returns in cycle t+1.
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input int extra, input int npush, input bit timed, input bit push_done,
                        output int t);
      int   n;
      exp_t e;
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      @(posedge clk); #1;
      store_req  = 1'b1;
      store_addr = a;
      store_data = d;
      store_size = sz;
      t = cyc;
      for (int i = 0; i < npush; i++) begin
         e.a = a + 32'(i);
         e.d = d[8*i +: 8];
         e.c = timed ? (t + 2 + extra + i) : -1;
         exp_q.push_back(e);
      end
      if (push_done) done_q.push_back(timed ? (t + 2 + extra + n) : -1);
      @(posedge clk); #1;
      store_req = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && done_q.size() == 0 && store_ready) break;
      end
      chk({tag, "_drained"}, exp_q.size() + done_q.size(), 0);
      chk({tag, "_idle"}, store_ready, 1);
      exp_q.delete();
      done_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int   t;
      exp_t e;
      rst = 1'b1; rdy = 1'b1; bus_gnt = 1'b1; store_req = 1'b0;
      store_addr = 32'd0; store_data = 32'd0; store_size = 2'b00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", store_ready, 1);
      chk("rst_done", store_done, 0);
      chk("rst_busreq", bus_req, 0);
      chk("rst_wr", wr_ram, 0);
      chk("rst_addr", addr_ram, 0);
      chk("rst_dout", dout_ram, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Full-speed word store with exact latency
      issue(32'h0000_1000, 32'hA1B2_C3D4, 2'b10, 0, 4, 1, 1, t);
      wait_cyc(t + 1);
      chk("sw_waitgnt_busreq", bus_req, 1);
      chk("sw_waitgnt_wr", wr_ram, 0);
      chk("sw_waitgnt_addr", addr_ram, 0);
      wait_cyc(t + 6);
      chk("sw_done_pulse", store_done, 1);
      chk("sw_ready_in_done", store_ready, 0);
      @(negedge clk);
      chk("sw_ready_again", store_ready, 1);
      chk("sw_done_one_cycle", store_done, 0);
      drain("sw");

      // Byte store to IO space
      issue(32'h0003_0000, 32'h0000_0041, 2'b00, 0, 1, 1, 1, t);
      wait_cyc(t + 3);
      chk("sb_done_pulse", store_done, 1);
      drain("sb_io");

      // Size 11 behaves as a word, IO address
      issue(32'h0003_0004, 32'h1122_3344, 2'b11, 0, 4, 1, 1, t);
      drain("sz11_io");

      // Misaligned halfword across 0x20000 with a 2-cycle rdy stall
      issue(32'h0001_FFFF, 32'h0000_5566, 2'b01, 0, 2, 0, 1, t);
      wait_cyc(t + 2);
      chk("sh_first_wr", wr_ram, 1);
      @(posedge clk); #1 rdy = 1'b0;
      @(negedge clk);
      chk("sh_pause_wr", wr_ram, 0);
      chk("sh_pause_addr", addr_ram, 32'h0002_0000);
      chk("sh_pause_dout", dout_ram, 8'h55);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sh_pause2_wr", wr_ram, 0);
      chk("sh_pause2_addr", addr_ram, 32'h0002_0000);
      @(posedge clk); #1 rdy = 1'b1;
      drain("sh_stall");

      // Grant withheld for 3 cycles in WAIT_GNT
      bus_gnt = 1'b0;
      issue(32'h0000_5000, 32'h0BAD_F00D, 2'b10, 3, 4, 1, 1, t);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("gnt_wait_busreq", bus_req, 1);
         chk("gnt_wait_wr", wr_ram, 0);
      end
      @(posedge clk); #1 bus_gnt = 1'b1;
      drain("gnt_delay");

      // Reset after the second byte of a word store
      issue(32'h0000_2000, 32'hDEAD_BEEF, 2'b10, 0, 2, 1, 0, t);
      wait_cyc(t + 3);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("abort_wr", wr_ram, 0);
      chk("abort_done", store_done, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", store_ready, 1);
      chk("abort_busreq", bus_req, 0);
      chk("abort_addr", addr_ram, 0);
      repeat (8) @(negedge clk);
      drain("abort");

      // store_req held high through a word store, fields switched to a byte store
      @(posedge clk); #1;
      store_req = 1'b1; store_addr = 32'h0000_6000; store_data = 32'hCAFE_F00D; store_size = 2'b10;
      t = cyc;
      for (int i = 0; i < 4; i++) begin
         e.a = 32'h0000_6000 + 32'(i);
         e.d = store_data[8*i +: 8];
         e.c = t + 2 + i;
         exp_q.push_back(e);
      end
      done_q.push_back(t + 6);
      @(posedge clk); #1;
      store_addr = 32'h0000_4000; store_data = 32'h0000_0077; store_size = 2'b00;
      e.a = 32'h0000_4000; e.d = 8'h77; e.c = t + 9;
      exp_q.push_back(e);
      done_q.push_back(t + 10);
      wait_cyc(t + 6);
      chk("hold_req_not_ready", store_ready, 0);
      wait_cyc(t + 7);
      chk("hold_req_ready", store_ready, 1);
      @(posedge clk); #1 store_req = 1'b0;
      drain("hold_req");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
